dimacs_stream_parser: RTL



---
 rtl/satswarmv2_pkg.sv | 55 +++++
 rtl/dimacs_dec_accum.sv | 43 ++++
 rtl/dimacs_stream_parser.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/satswarmv2_pkg.sv
// Shared SatSwarm types: DIMACS front-end states, error codes and
// ASCII constants used by the stream parser.
package satswarmv2_pkg;

  typedef enum logic [3:0] {
    LINE_START,
    COMMENT,
    HDR_KW,
    HDR_V,
    HDR_C,
    BODY,
    DRAIN,
    FLUSH,
    DONE,
    ERR
  } dimacs_state_e;

  typedef enum logic [2:0] {
    E_NONE           = 3'd0,
    E_BAD_CHAR       = 3'd1,
    E_NO_HEADER      = 3'd2,
    E_VAR_RANGE      = 3'd3,
    E_OVERFLOW       = 3'd4,
    E_UNTERMINATED   = 3'd5,
    E_COUNT_MISMATCH = 3'd6
  } dimacs_err_e;

  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_C     = 8'h63;
  localparam logic [7:0] ASC_P     = 8'h70;
  localparam logic [7:0] ASC_PCT   = 8'h25;
  localparam logic [7:0] ASC_N     = 8'h6E;
  localparam logic [7:0] ASC_F     = 8'h66;

  localparam logic [31:0] DIMACS_MAX_MAG = 32'h7FFF_FFFF;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

  function automatic logic is_blank(input logic [7:0] b);
    return (b == ASC_SP) || (b == ASC_TAB);
  endfunction

  function automatic logic is_ws(input logic [7:0] b);
    return is_blank(b) || (b == ASC_CR) || (b == ASC_LF);
  endfunction

endpackage

// File: rtl/dimacs_dec_accum.sv
// Decimal accumulator: acc*10+digit in 35 bits with a 2^31-1 limit.
// sum/ovf always describe shifting the next digit into the held value.
module dimacs_dec_accum
  import satswarmv2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [3:0]  digit,
  output logic [31:0] acc,
  output logic [31:0] sum,
  output logic        ovf
);

  logic [31:0] acc_q, acc_d;
  logic [34:0] wide;

  always_comb begin
    wide = {acc_q, 3'b000}
         + {2'b00, acc_q, 1'b0}
         + {31'd0, digit};
    ovf  = wide > {3'b000, DIMACS_MAX_MAG};
    sum  = wide[31:0];
    acc_d = acc_q;
    if (clr) begin
      acc_d = shift ? {28'd0, digit} : '0;
    end else if (shift) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dimacs_stream_parser.sv
// DIMACS CNF byte-stream parser feeding the satswarm host load port.
// One output register; first error is latched and stops the stream.
module dimacs_stream_parser
  import satswarmv2_pkg::*;
#(
  parameter int LIT_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LIT_W-1:0] out_literal,
  output logic             out_clause_end,
  output logic             hdr_valid,
  output logic [CNT_W-1:0] num_vars,
  output logic [CNT_W-1:0] num_clauses,
  output logic [CNT_W-1:0] clause_count,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code
);

  dimacs_state_e state_q, state_d;
  dimacs_err_e   ecode_q, ecode_d, err_v;

  logic [2:0]       kw_q, kw_d;
  logic             neg_q, neg_d;
  logic             dig_q, dig_d;
  logic             pend_q, pend_d;
  logic             hdr_q, hdr_d;
  logic             ov_q, ov_d;
  logic             oce_q, oce_d;
  logic [LIT_W-1:0] olit_q, olit_d;
  logic [CNT_W-1:0] nv_q, nv_d;
  logic [CNT_W-1:0] nc_q, nc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             acc_clr, acc_shift, acc_ovf;
  logic [31:0]      acc, acc_sum, mag;
  logic [LIT_W-1:0] lit_mag;
  logic             fire, body, term;
  logic             b_dig, b_blank, b_ws, b_lf;

  dimacs_dec_accum u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .shift (acc_shift),
    .digit (in_byte[3:0]),
    .acc   (acc),
    .sum   (acc_sum),
    .ovf   (acc_ovf)
  );

  assign in_ready = !rst
    && !(state_q inside {DONE, ERR, FLUSH})
    && (!ov_q || out_ready);

  assign fire    = in_valid && in_ready;
  assign b_dig   = is_digit(in_byte);
  assign b_blank = is_blank(in_byte);
  assign b_ws    = is_ws(in_byte);
  assign b_lf    = in_byte == ASC_LF;

  always_comb begin
    state_d = state_q;
    ecode_d = ecode_q;
    kw_d    = kw_q;
    neg_d   = neg_q;
    dig_d   = dig_q;
    pend_d  = pend_q;
    hdr_d   = hdr_q;
    nv_d    = nv_q;
    nc_d    = nc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    olit_d  = olit_q;
    oce_d   = oce_q;
    err_v     = E_NONE;
    acc_clr   = 1'b0;
    acc_shift = 1'b0;
    body      = 1'b0;
    term      = 1'b0;
    // A digit on the token's final byte has not reached acc yet
    if (b_dig) begin
      mag = dig_q ? acc_sum : {28'd0, in_byte[3:0]};
    end else begin
      mag = acc;
    end
    lit_mag = LIT_W'(mag);

    if (ov_q && out_ready) ov_d = 1'b0;

    if (fire) begin
      unique case (state_q)
        LINE_START: begin
          unique case (1'b1)
            b_ws: begin
            end
            in_byte == ASC_C: state_d = COMMENT;
            in_byte == ASC_P: begin
              if (hdr_q) begin
                err_v = E_BAD_CHAR;
              end else begin
                state_d = HDR_KW;
                kw_d    = '0;
              end
            end
            in_byte == ASC_PCT: state_d = DRAIN;
            b_dig, in_byte == ASC_MINUS: begin
              state_d = BODY;
              body    = 1'b1;
            end
            default: err_v = E_BAD_CHAR;
          endcase
        end
        COMMENT: begin
          if (b_lf) state_d = LINE_START;
        end
        HDR_KW: begin
          if (b_lf) begin
            state_d = LINE_START;
          end else begin
            unique case (kw_q)
              3'd0: begin
                if (b_blank) kw_d = 3'd1;
                else err_v = E_BAD_CHAR;
              end
              3'd1: begin
                if (in_byte == ASC_C) kw_d = 3'd2;
                else if (!b_blank) err_v = E_BAD_CHAR;
              end
              3'd2: begin
                if (in_byte == ASC_N) kw_d = 3'd3;
                else err_v = E_BAD_CHAR;
              end
              3'd3: begin
                if (in_byte == ASC_F) kw_d = 3'd4;
                else err_v = E_BAD_CHAR;
              end
              3'd4: begin
                if (b_blank) kw_d = 3'd5;
                else err_v = E_BAD_CHAR;
              end
              default: begin
                if (b_dig) begin
                  state_d   = HDR_V;
                  acc_clr   = 1'b1;
                  acc_shift = 1'b1;
                end else if (!b_blank) begin
                  err_v = E_BAD_CHAR;
                end
              end
            endcase
          end
        end
        HDR_V: begin
          if (b_lf) begin
            state_d = LINE_START;
          end else if (b_dig) begin
            acc_shift = 1'b1;
          end else if (b_blank) begin
            nv_d    = CNT_W'(acc);
            state_d = HDR_C;
            kw_d    = '0;
          end else begin
            err_v = E_BAD_CHAR;
          end
        end
        // kw_q here: 0 before digits, 1 in digits, 2 after digits
        HDR_C: begin
          if (b_lf) begin
            if (kw_q != 3'd0) begin
              nc_d  = CNT_W'(acc);
              hdr_d = 1'b1;
            end
            state_d = LINE_START;
          end else if (b_dig) begin
            if (kw_q == 3'd2) begin
              err_v = E_BAD_CHAR;
            end else begin
              acc_clr   = kw_q == 3'd0;
              acc_shift = 1'b1;
              kw_d      = 3'd1;
            end
          end else if (b_ws) begin
            if (kw_q == 3'd1) kw_d = 3'd2;
          end else begin
            err_v = E_BAD_CHAR;
          end
        end
        BODY:    body = 1'b1;
        default: begin
        end
      endcase

      if (body) begin
        if (in_byte == ASC_MINUS) begin
          if (neg_q || dig_q) err_v = E_BAD_CHAR;
          else if (!hdr_q) err_v = E_NO_HEADER;
          else neg_d = 1'b1;
        end else if (b_dig) begin
          if (!hdr_q) begin
            err_v = E_NO_HEADER;
          end else begin
            acc_clr   = !dig_q;
            acc_shift = 1'b1;
            dig_d     = 1'b1;
            term      = in_last;
          end
        end else if (b_ws) begin
          if (b_lf) state_d = LINE_START;
          if (dig_q) term = 1'b1;
          else if (neg_q) err_v = E_BAD_CHAR;
        end else begin
          err_v = E_BAD_CHAR;
        end
      end

      if (acc_shift && !acc_clr && acc_ovf) err_v = E_OVERFLOW;

      if (term && err_v == E_NONE) begin
        neg_d = 1'b0;
        dig_d = 1'b0;
        if (CNT_W'(mag) > nv_q) begin
          err_v = E_VAR_RANGE;
        end else begin
          ov_d = 1'b1;
          if (mag == '0) begin
            olit_d = '0;
            oce_d  = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            pend_d = 1'b0;
          end else begin
            olit_d = neg_q ? -lit_mag : lit_mag;
            oce_d  = 1'b0;
            pend_d = 1'b1;
          end
        end
      end

      if (err_v != E_NONE) begin
        state_d = ERR;
        ecode_d = err_v;
      end else if (in_last) begin
        state_d = FLUSH;
      end
    end else if (state_q == FLUSH) begin
      if (pend_q) begin
        state_d = ERR;
        ecode_d = E_UNTERMINATED;
      end else if (cnt_q != nc_q) begin
        state_d = ERR;
        ecode_d = E_COUNT_MISMATCH;
      end else if (!ov_q) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LINE_START;
      ecode_q <= E_NONE;
      kw_q    <= '0;
      neg_q   <= 1'b0;
      dig_q   <= 1'b0;
      pend_q  <= 1'b0;
      hdr_q   <= 1'b0;
      nv_q    <= '0;
      nc_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      olit_q  <= '0;
      oce_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ecode_q <= ecode_d;
      kw_q    <= kw_d;
      neg_q   <= neg_d;
      dig_q   <= dig_d;
      pend_q  <= pend_d;
      hdr_q   <= hdr_d;
      nv_q    <= nv_d;
      nc_q    <= nc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      olit_q  <= olit_d;
      oce_q   <= oce_d;
    end
  end

  assign out_valid      = ov_q;
  assign out_literal    = olit_q;
  assign out_clause_end = oce_q;
  assign hdr_valid      = hdr_q;
  assign num_vars       = nv_q;
  assign num_clauses    = nc_q;
  assign clause_count   = cnt_q;
  assign done           = state_q == DONE;
  assign error          = state_q == ERR;
  assign err_code       = ecode_q;

endmodule
